i2s_rx_deserializer: RTL and testbench
======================================

// Module: i2s_rx_deserializer
// PURPOSE
//   Receive side of the codec I2S link: deserializes ADC data from the ADAU1761 (I2S_MOSI, bclk, LR)
//   into parallel left/right samples in the clk domain. Complements the existing hphone transmit path;
//   feeds line-in audio to music_player/adsr/echo and wave_display_top with a one-cycle new_sample pulse.
// PARAMETERS
//   SAMPLE_WIDTH  24  bits captured per channel slot, MSB first; slot bits beyond this are ignored
//   SYNC_STAGES   2   flip-flop stages on each async I2S input (minimum 2)
// PORTS
//   clk           in   1             system clock (100 MHz); one clock domain
//   reset_n       in   1             asynchronous, active-low reset
//   i2s_bclk      in   1             codec bit clock, async to clk, <= clk/8
//   i2s_lr        in   1             codec channel clock; 0 = left slot, 1 = right slot
//   i2s_sdata     in   1             codec serial data, valid on bclk rising edge
//   left_sample   out  SAMPLE_WIDTH  last complete left sample, two's complement
//   right_sample  out  SAMPLE_WIDTH  last complete right sample, two's complement
//   new_sample    out  1             1-cycle pulse: left_sample/right_sample just updated as a pair
//   frame_error   out  1             1-cycle pulse: slot ended before SAMPLE_WIDTH bits captured
//   mono_sample   out  SAMPLE_WIDTH  (only when I2S_RX_MONO_MIX_EN) (L+R)>>>1
// BEHAVIOUR
//   - Reset: all outputs 0, shift reg 0, bit count 0, FSM = HUNT. Async assert, sync to clk on release.
//   - Inputs pass SYNC_STAGES flops; bclk_rise = synced bclk 0->1 (edge detect on synced copies).
//   - All capture happens only on bclk_rise cycles; lr and sdata sampled from synced copies same cycle.
//   - FSM: HUNT   : wait for lr 1->0 seen on a bclk_rise -> DELAY (frame alignment starts on left).
//          DELAY  : skip exactly one bclk_rise (I2S 1-bit delay) -> SHIFT, count=0.
//          SHIFT  : shift sdata in MSB-first, count++; when count reaches SAMPLE_WIDTH -> LATCH event,
//                   -> WAIT.
//          WAIT   : ignore remaining bits until lr toggles on a bclk_rise -> DELAY for the next slot.
//   - LR toggle in SHIFT before SAMPLE_WIDTH bits: frame_error pulse, partial word discarded, no
//     new_sample for that frame, pending left discarded, FSM -> DELAY for the new slot.
//   - Left slot complete: hold in left_hold (not visible). Right slot complete: on the next clk,
//     left_sample<=left_hold, right_sample<=shift word, new_sample=1 for exactly one cycle.
//     Latency: 1 clk after the bclk_rise that samples the right LSB (plus SYNC_STAGES from pins).
//   - Right slot completing with no valid left held (after HUNT or error): no pulse, word dropped.
//   - Toggle of lr on the same bclk_rise as the final bit is legal: bit is captured, slot counts as
//     complete, FSM -> DELAY.
//   - bclk stopped: outputs hold indefinitely; no timeout.
//   - reset_n low mid-frame: immediate clear to reset values; after release, re-HUNT for a left edge.
//   - frame_error and new_sample never asserted in the same cycle.
// CONFIGURATION
//   I2S_RX_MONO_MIX_EN defined: mono_sample port present; computed with SAMPLE_WIDTH+1 bit sum,
//     arithmetic shift right 1, registered in the same cycle as left/right (updates with new_sample).
//   Not defined: mono_sample port and adder absent; all other behaviour identical.
// TESTING
//   1. Reset, then frames L=24'h123456, R=24'hFEDCBA, 32 bclk/slot -> new_sample once per frame, outputs
//      match exactly, 1 clk after right LSB bclk_rise.
//   2. Start mid right slot after reset -> first partial frame dropped, no new_sample until first full
//      left+right pair; frame_error stays 0.
//   3. Left slot cut to 16 bclks -> one frame_error pulse, no new_sample that frame; next good frame
//      L=24'h000001, R=24'h800000 decoded correctly.
//   4. SAMPLE_WIDTH bits exactly (24 bclk/slot, lr toggles on LSB edge) -> L=24'h7FFFFF, R=24'h800000
//      captured, pulse per frame.
//   5. Assert reset_n low mid left slot -> outputs 0 same cycle; after release, resync on next lr fall.
//   6. MONO_MIX_EN: L=24'h7FFFFF, R=24'h7FFFFF -> mono 24'h7FFFFF; L=24'h800000, R=24'h000000
//      -> mono 24'hC00000; without macro, design compiles with mono_sample absent.

Source files
------------

// File: rtl/i2s_rx_deserializer.sv
// I2S receive deserializer: synchronizes the codec bit stream into the clk domain and emits paired
// left/right samples. Optional mono mix output is enabled by defining I2S_RX_MONO_MIX_EN.
module i2s_rx_deserializer #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i2s_bclk,
    input  logic                    i2s_lr,
    input  logic                    i2s_sdata,
    output logic [SAMPLE_WIDTH-1:0] left_sample,
    output logic [SAMPLE_WIDTH-1:0] right_sample,
    output logic                    new_sample,
    output logic                    frame_error,
    output logic [1:0]              fsm_state
`ifdef I2S_RX_MONO_MIX_EN
    ,
    output logic [SAMPLE_WIDTH-1:0] mono_sample
`endif
);

    localparam int CNT_W = $clog2(SAMPLE_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_WIDTH - 1);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        DELAY = 2'd1,
        SHIFT = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t                  state;
    logic [1:0]              rst_pipe;
    logic                    rst_n;
    logic [SYNC_STAGES-1:0]  bclk_sync;
    logic [SYNC_STAGES-1:0]  lr_sync;
    logic [SYNC_STAGES-1:0]  sdata_sync;
    logic                    bclk_d;
    logic                    lr_prev;
    logic                    left_valid;
    logic [CNT_W-1:0]        bit_cnt;
    logic [SAMPLE_WIDTH-1:0] shift_reg;
    logic [SAMPLE_WIDTH-1:0] left_hold;
    logic                    bclk_s;
    logic                    lr_s;
    logic                    sdata_s;
    logic                    bclk_rise;
    logic                    lr_toggle;
    logic [SAMPLE_WIDTH-1:0] word_next;

    // Reset asserts asynchronously but is released on a clk edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_pipe <= 2'b00;
        else          rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_sync  <= '0;
            lr_sync    <= '0;
            sdata_sync <= '0;
            bclk_d     <= 1'b0;
        end else begin
            bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], i2s_bclk};
            lr_sync    <= {lr_sync[SYNC_STAGES-2:0], i2s_lr};
            sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], i2s_sdata};
            bclk_d     <= bclk_s;
        end
    end

    assign bclk_s    = bclk_sync[SYNC_STAGES-1];
    assign lr_s      = lr_sync[SYNC_STAGES-1];
    assign sdata_s   = sdata_sync[SYNC_STAGES-1];
    assign bclk_rise = bclk_s & ~bclk_d;
    assign lr_toggle = lr_s ^ lr_prev;
    assign word_next = {shift_reg[SAMPLE_WIDTH-2:0], sdata_s};
    assign fsm_state = state;

`ifdef I2S_RX_MONO_MIX_EN
    logic signed [SAMPLE_WIDTH:0] mono_sum;
    assign mono_sum = $signed({left_hold[SAMPLE_WIDTH-1], left_hold})
                    + $signed({word_next[SAMPLE_WIDTH-1], word_next});
`endif

    // new_sample is a valid-only strobe with no ready: the consumer must take the pair on the
    // cycle it is high; left_sample/right_sample then hold until the next strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HUNT;
            lr_prev      <= 1'b0;
            left_valid   <= 1'b0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            left_hold    <= '0;
            left_sample  <= '0;
            right_sample <= '0;
            new_sample   <= 1'b0;
            frame_error  <= 1'b0;
`ifdef I2S_RX_MONO_MIX_EN
            mono_sample  <= '0;
`endif
        end else begin
            new_sample  <= 1'b0;
            frame_error <= 1'b0;
            if (bclk_rise) begin
                lr_prev <= lr_s;
                case (state)
                    HUNT: begin
                        if (lr_prev && !lr_s) state <= DELAY;
                    end
                    DELAY: begin
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                    SHIFT: begin
                        if (bit_cnt == LAST_BIT) begin
                            // Final bit may coincide with the lr edge that opens the next slot.
                            shift_reg <= word_next;
                            state     <= lr_toggle ? DELAY : WAIT;
                            if (!lr_prev) begin
                                left_hold  <= word_next;
                                left_valid <= 1'b1;
                            end else begin
                                left_valid <= 1'b0;
                                if (left_valid) begin
                                    left_sample  <= left_hold;
                                    right_sample <= word_next;
                                    new_sample   <= 1'b1;
`ifdef I2S_RX_MONO_MIX_EN
                                    mono_sample  <= mono_sum[SAMPLE_WIDTH:1];
`endif
                                end
                            end
                        end else if (lr_toggle) begin
                            frame_error <= 1'b1;
                            left_valid  <= 1'b0;
                            bit_cnt     <= '0;
                            state       <= DELAY;
                        end else begin
                            shift_reg <= word_next;
                            bit_cnt   <= bit_cnt + CNT_W'(1);
                        end
                    end
                    WAIT: begin
                        if (lr_toggle) state <= DELAY;
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Directed and randomized bench for i2s_rx_deserializer; expectations come from a slot-level model
// of the rise-by-rise lr/sdata stream. Define I2S_RX_MONO_MIX_EN to also exercise mono_sample.
module tb_i2s_rx_deserializer;
    localparam int W       = 24;
    localparam int EXP_LAT = 3;  // two sync stages plus the registered output

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         i2s_bclk = 1'b0;
    logic         i2s_lr = 1'b1;
    logic         i2s_sdata = 1'b0;
    logic [W-1:0] left_sample;
    logic [W-1:0] right_sample;
    logic         new_sample;
    logic         frame_error;
    logic [1:0]   fsm_state;
`ifdef I2S_RX_MONO_MIX_EN
    logic [W-1:0] mono_sample;
`endif

    always #5 clk = ~clk;

    i2s_rx_deserializer #(.SAMPLE_WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .i2s_bclk(i2s_bclk),
        .i2s_lr(i2s_lr),
        .i2s_sdata(i2s_sdata),
        .left_sample(left_sample),
        .right_sample(right_sample),
        .new_sample(new_sample),
        .frame_error(frame_error),
        .fsm_state(fsm_state)
`ifdef I2S_RX_MONO_MIX_EN
        ,
        .mono_sample(mono_sample)
`endif
    );

    int cyc = 0;
    int rise_cyc = 0;
    int errors = 0;
    int checks = 0;
    int obs_err = 0;
    int exp_err = 0;
    int both_cnt = 0;

    logic [2*W-1:0] obs_q[$];
    logic [2*W-1:0] exp_q[$];
    int             lat_q[$];
    logic [W-1:0]   obs_mono[$];
    logic [W-1:0]   exp_mono[$];
    logic           seq_lr[$];
    logic           seq_sd[$];
    logic           slot_lr[$];
    int             slot_len[$];
    logic [W-1:0]   slot_word[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard capture, sampled away from the active edge.
    always @(negedge clk) begin
        if (new_sample) begin
            obs_q.push_back({left_sample, right_sample});
            lat_q.push_back(cyc - rise_cyc);
`ifdef I2S_RX_MONO_MIX_EN
            obs_mono.push_back(mono_sample);
`endif
        end
        if (frame_error) obs_err++;
        if (new_sample && frame_error) both_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mono_of(input logic [W-1:0] l, input logic [W-1:0] r);
        int sum;
        sum = int'($signed(l)) + int'($signed(r));
        return W'(sum >>> 1);
    endfunction

    task automatic clear_slots();
        slot_lr.delete();
        slot_len.delete();
        slot_word.delete();
    endtask

    task automatic add_slot(input logic lr_v, input int len, input logic [W-1:0] word);
        slot_lr.push_back(lr_v);
        slot_len.push_back(len);
        slot_word.push_back(word);
    endtask

    // One entry per bclk rise; a slot's MSB sits two rises after its first rise.
    task automatic build_seq();
        int pos;
        seq_lr.delete();
        seq_sd.delete();
        foreach (slot_len[k]) begin
            for (int i = 0; i < slot_len[k]; i++) begin
                seq_lr.push_back(slot_lr[k]);
                seq_sd.push_back(1'($urandom_range(0, 1)));
            end
        end
        pos = 0;
        foreach (slot_len[k]) begin
            for (int b = 0; b < W; b++) begin
                int idx;
                idx = pos + 2 + b;
                if (idx <= pos + slot_len[k] && idx < seq_sd.size()) seq_sd[idx] = slot_word[k][W-1-b];
            end
            pos += slot_len[k];
        end
    endtask

    // Slot-level reference: split the rise stream at lr changes, starting at the first left edge.
    task automatic model_run();
        int n, s, j, last;
        logic have_left;
        logic [W-1:0] hold, word;
        exp_q.delete();
        exp_mono.delete();
        exp_err = 0;
        n = seq_lr.size();
        s = -1;
        for (int i = 1; i < n; i++) if (s < 0 && seq_lr[i-1] == 1'b1 && seq_lr[i] == 1'b0) s = i;
        have_left = 1'b0;
        hold = '0;
        word = '0;
        while (s >= 0) begin
            j = s + 1;
            while (j < n && seq_lr[j] == seq_lr[s]) j++;
            last = s + W + 1;
            if (last < n && last <= j) begin
                for (int b = 0; b < W; b++) word[W-1-b] = seq_sd[s+2+b];
                if (seq_lr[s] == 1'b0) begin
                    hold = word;
                    have_left = 1'b1;
                end else begin
                    if (have_left) begin
                        exp_q.push_back({hold, word});
                        exp_mono.push_back(mono_of(hold, word));
                    end
                    have_left = 1'b0;
                end
            end else if (j < n) begin
                exp_err++;
                have_left = 1'b0;
            end
            s = (j < n) ? j : -1;
        end
    endtask

    task automatic drive_rise(input logic lr_v, input logic sd_v);
        @(posedge clk); #1;
        i2s_lr = lr_v;
        i2s_sdata = sd_v;
        repeat (4) @(posedge clk);
        #1;
        i2s_bclk = 1'b1;
        rise_cyc = cyc;
        repeat (5) @(posedge clk);
        #1;
        i2s_bclk = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        i2s_bclk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic run_case(input string tag, input bit do_reset);
        int b_obs, b_err;
        logic [2*W-1:0] hold_exp;
        if (do_reset) apply_reset();
        build_seq();
        model_run();
        b_obs = obs_q.size();
        b_err = obs_err;
        foreach (seq_lr[i]) drive_rise(seq_lr[i], seq_sd[i]);
        repeat (30) @(posedge clk);
        @(negedge clk);
        check({tag, "_count"}, 64'(obs_q.size() - b_obs), 64'(exp_q.size()));
        check({tag, "_errs"}, 64'(obs_err - b_err), 64'(exp_err));
        foreach (exp_q[i]) begin
            if (b_obs + i < obs_q.size()) begin
                check($sformatf("%s_pair%0d", tag, i), 64'(obs_q[b_obs+i]), 64'(exp_q[i]));
                check($sformatf("%s_lat%0d", tag, i), 64'(lat_q[b_obs+i]), 64'(EXP_LAT));
`ifdef I2S_RX_MONO_MIX_EN
                check($sformatf("%s_mono%0d", tag, i), 64'(obs_mono[b_obs+i]), 64'(exp_mono[i]));
`endif
            end
        end
        hold_exp = (exp_q.size() > 0) ? exp_q[exp_q.size()-1] : '0;
        if (!do_reset && exp_q.size() == 0) hold_exp = '0;
        check({tag, "_hold"}, 64'({left_sample, right_sample}), 64'(hold_exp));
        clear_slots();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_left", 64'(left_sample), 64'(0));
        check("reset_right", 64'(right_sample), 64'(0));
        check("reset_new", 64'(new_sample), 64'(0));
        check("reset_ferr", 64'(frame_error), 64'(0));

        // Nominal 32-rise slots
        clear_slots();
        add_slot(1'b1, 4, '0);
        for (int f = 0; f < 3; f++) begin
            add_slot(1'b0, 32, 24'h123456);
            add_slot(1'b1, 32, 24'hFEDCBA);
        end
        add_slot(1'b0, 3, '0);
        run_case("t1", 1'b1);
        check("t1_left", 64'(left_sample), 64'h123456);
        check("t1_right", 64'(right_sample), 64'hFEDCBA);

        // Start mid right slot, then mid left slot
        add_slot(1'b1, 12, W'($urandom()));
        add_slot(1'b0, 32, W'($urandom()));
        add_slot(1'b1, 32, W'($urandom()));
        add_slot(1'b0, 3, '0);
        run_case("t2a", 1'b1);
        add_slot(1'b0, 10, W'($urandom()));
        add_slot(1'b1, 32, W'($urandom()));
        add_slot(1'b0, 32, W'($urandom()));
        add_slot(1'b1, 32, W'($urandom()));
        add_slot(1'b0, 3, '0);
        run_case("t2b", 1'b1);

        // Short left slot
        add_slot(1'b1, 4, '0);
        add_slot(1'b0, 32, W'($urandom()));
        add_slot(1'b1, 32, W'($urandom()));
        add_slot(1'b0, 16, W'($urandom()));
        add_slot(1'b1, 32, W'($urandom()));
        add_slot(1'b0, 32, 24'h000001);
        add_slot(1'b1, 32, 24'h800000);
        add_slot(1'b0, 3, '0);
        run_case("t3", 1'b1);
        check("t3_left", 64'(left_sample), 64'h000001);
        check("t3_right", 64'(right_sample), 64'h800000);

        // Exact-fit slots: lr edge lands on the LSB rise
        add_slot(1'b1, 4, '0);
        for (int f = 0; f < 3; f++) begin
            add_slot(1'b0, W + 1, 24'h7FFFFF);
            add_slot(1'b1, W + 1, 24'h800000);
        end
        add_slot(1'b0, 3, '0);
        run_case("t4", 1'b1);
        check("t4_left", 64'(left_sample), 64'h7FFFFF);
        check("t4_right", 64'(right_sample), 64'h800000);

        // Reset mid left slot, then resync
        add_slot(1'b1, 4, '0);
        add_slot(1'b0, 32, W'($urandom()));
        add_slot(1'b1, 32, W'($urandom()));
        add_slot(1'b0, 10, W'($urandom()));
        run_case("t5a", 1'b1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("t5_rst_left", 64'(left_sample), 64'(0));
        check("t5_rst_right", 64'(right_sample), 64'(0));
        check("t5_rst_new", 64'(new_sample), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        add_slot(1'b0, 15, W'($urandom()));
        add_slot(1'b1, 32, W'($urandom()));
        add_slot(1'b0, 32, W'($urandom()));
        add_slot(1'b1, 32, W'($urandom()));
        add_slot(1'b0, 3, '0);
        run_case("t5b", 1'b0);

`ifdef I2S_RX_MONO_MIX_EN
        add_slot(1'b1, 4, '0);
        add_slot(1'b0, 32, 24'h7FFFFF);
        add_slot(1'b1, 32, 24'h7FFFFF);
        add_slot(1'b0, 32, 24'h800000);
        add_slot(1'b1, 32, 24'h000000);
        add_slot(1'b0, 3, '0);
        run_case("t6", 1'b1);
        check("t6_mono_last", 64'(mono_sample), 64'hC00000);
`endif

        // Randomized data and slot lengths, including short slots
        for (int r = 0; r < 2; r++) begin
            add_slot(1'b1, 4, '0);
            for (int f = 0; f < 6; f++) begin
                add_slot(1'b0, $urandom_range(20, 34), W'($urandom()));
                add_slot(1'b1, $urandom_range(20, 34), W'($urandom()));
            end
            add_slot(1'b0, 3, '0);
            run_case($sformatf("rnd%0d", r), 1'b1);
        end

        check("pulse_overlap", 64'(both_cnt), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
